d_cache_tag_array: RTL

- Parametrised N-way set-associative tag store for the data cache; next generation of the single-way 64-entry tag RAM.
- Holds tag, valid and dirty per way, plus tree-PLRU per set.
- Performs registered hit compare and victim selection.
- Runs a flush FSM that sweeps all lines, hands every dirty line to the write-back path over a valid/ready handshake, then invalidates the whole array.

---
 rtl/dcache_tag_pkg.sv | 46 ++++
 rtl/d_cache_tag_way_ram.sv | 28 ++
 rtl/d_cache_tag_array.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_tag_pkg.sv
// Shared types and tree-PLRU helpers for the data-cache tag store.
// PLRU bits point toward the least-recently-used side; bit0 is the root.
package dcache_tag_pkg;

  localparam int TAG_MAX = 64;

  typedef enum logic [2:0] {
    F_IDLE,
    F_RD,
    F_CHK,
    F_WB,
    F_NEXT,
    F_DONE
  } flush_state_e;

  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [TAG_MAX-1:0] tag;
  } line_t;

  function automatic logic [2:0] plru_update(input logic [2:0] plru,
                                             input logic [1:0] way,
                                             input int         ways);
    logic [2:0] p;
    p = plru;
    if (ways == 2) begin
      p[0] = ~way[0];
    end else if (ways == 4) begin
      p[0] = ~way[1];
      if (way[1]) p[2] = ~way[0];
      else        p[1] = ~way[0];
    end
    return p;
  endfunction

  function automatic logic [1:0] plru_victim(input logic [2:0] plru,
                                             input int         ways);
    logic [1:0] v;
    v = 2'b00;
    if (ways == 2)      v = {1'b0, plru[0]};
    else if (ways == 4) v = plru[0] ? {1'b1, plru[2]} : {1'b0, plru[1]};
    return v;
  endfunction

endpackage

// File: rtl/d_cache_tag_way_ram.sv
// One way of tag storage: SETS x TAG_W synchronous RAM, registered read.
// Read data holds when en_i is low; contents are not reset.
module d_cache_tag_way_ram #(
  parameter  int SETS  = 64,
  parameter  int TAG_W = 55,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [TAG_W-1:0] wdata_i,
  output logic [TAG_W-1:0] rdata_o
);

  logic [TAG_W-1:0] mem_q [SETS];
  logic [TAG_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/d_cache_tag_array.sv
// N-way tag store: registered hit/victim lookup, tree-PLRU, and a flush
// sweep that offers dirty lines to write-back before invalidating everything.
module d_cache_tag_array
  import dcache_tag_pkg::*;
#(
  parameter  int SETS  = 64,
  parameter  int WAYS  = 2,
  parameter  int TAG_W = 55,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [IDX_W-1:0] lk_index,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  output logic             rsp_vic_valid,
  output logic             rsp_vic_dirty,
  output logic [TAG_W-1:0] rsp_vic_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [WAY_W-1:0] wr_way,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid,
  input  logic             wr_dirty,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             flush_done,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [IDX_W-1:0] wb_index,
  output logic [WAY_W-1:0] wb_way,
  output logic [TAG_W-1:0] wb_tag
);

  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  flush_state_e            state_q, state_d;
  logic [IDX_W-1:0]        cnt_set_q, cnt_set_d;
  logic [WAY_W-1:0]        cnt_way_q, cnt_way_d;
  logic [TAG_W-1:0]        wb_tag_q, wb_tag_d;
  logic                    flush_done_q, flush_done_d;

  logic [SETS-1:0][WAYS-1:0]   valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0][PLRU_W-1:0] plru_q, plru_d;

  logic                    s1_vld_q;
  logic [IDX_W-1:0]        s1_idx_q;
  logic [TAG_W-1:0]        s1_tag_q;

  logic                    rsp_valid_q, rsp_hit_q, rsp_vic_valid_q, rsp_vic_dirty_q;
  logic [WAY_W-1:0]        rsp_way_q;
  logic [TAG_W-1:0]        rsp_vic_tag_q;

  logic                    wr_go, lk_acc, rd_go, last_line;
  logic [IDX_W-1:0]        rd_idx;
  logic [WAYS-1:0]         ram_en, ram_we;
  logic [WAYS-1:0][TAG_W-1:0] ram_rdata;

  logic                    hit, inv_found;
  logic [WAY_W-1:0]        hit_way, inv_way, vic_way;
  line_t                   vic_line;

  assign flush_busy = (state_q != F_IDLE);
  assign wr_go      = wr_en && !flush_busy;
  assign lk_ready   = !flush_busy && !wr_en;
  assign lk_acc     = lk_valid && lk_ready;
  assign rd_go      = lk_acc || (state_q == F_RD);
  assign rd_idx     = (state_q == F_RD) ? cnt_set_q : lk_index;
  assign last_line  = (cnt_set_q == IDX_W'(SETS - 1)) && (cnt_way_q == WAY_W'(WAYS - 1));

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign ram_we[w] = wr_go && (wr_way == WAY_W'(w));
    assign ram_en[w] = ram_we[w] || rd_go;
    d_cache_tag_way_ram #(.SETS(SETS), .TAG_W(TAG_W)) u_ram (
      .clk_i   (clk),
      .en_i    (ram_en[w]),
      .we_i    (ram_we[w]),
      .addr_i  (ram_we[w] ? wr_index : rd_idx),
      .wdata_i (wr_tag),
      .rdata_o (ram_rdata[w])
    );
  end

  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    vic_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[s1_idx_q][w] && (ram_rdata[w] == s1_tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[s1_idx_q][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    if (inv_found)     vic_way = inv_way;
    else if (WAYS > 1) vic_way = WAY_W'(plru_victim(3'(plru_q[s1_idx_q]), WAYS));
    vic_line.valid = valid_q[s1_idx_q][vic_way];
    vic_line.dirty = dirty_q[s1_idx_q][vic_way];
    vic_line.tag   = TAG_MAX'(ram_rdata[vic_way]);
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    plru_d  = plru_q;
    if (wr_go) begin
      valid_d[wr_index][wr_way] = wr_valid;
      dirty_d[wr_index][wr_way] = wr_dirty;
    end
    if (state_q == F_NEXT) begin
      valid_d[cnt_set_q][cnt_way_q] = 1'b0;
      dirty_d[cnt_set_q][cnt_way_q] = 1'b0;
    end
    if (WAYS > 1) begin
      if (s1_vld_q && hit)
        plru_d[s1_idx_q] = PLRU_W'(plru_update(3'(plru_d[s1_idx_q]), 2'(hit_way), WAYS));
      if (wr_go && wr_valid)
        plru_d[wr_index] = PLRU_W'(plru_update(3'(plru_d[wr_index]), 2'(wr_way), WAYS));
    end
    if (state_q == F_DONE) plru_d = '0;
  end

  always_comb begin
    state_d      = state_q;
    cnt_set_d    = cnt_set_q;
    cnt_way_d    = cnt_way_q;
    wb_tag_d     = wb_tag_q;
    flush_done_d = 1'b0;
    unique case (state_q)
      F_IDLE: if (flush_req) begin
        cnt_set_d = '0;
        cnt_way_d = '0;
        state_d   = F_RD;
      end
      F_RD:  state_d = F_CHK;
      F_CHK: begin
        if (valid_q[cnt_set_q][cnt_way_q] && dirty_q[cnt_set_q][cnt_way_q]) begin
          wb_tag_d = ram_rdata[cnt_way_q];
          state_d  = F_WB;
        end else begin
          state_d  = F_NEXT;
        end
      end
      F_WB:  if (wb_ready) state_d = F_NEXT;
      F_NEXT: begin
        if (last_line) begin
          state_d = F_DONE;
        end else begin
          state_d = F_RD;
          if (cnt_way_q == WAY_W'(WAYS - 1)) begin
            cnt_way_d = '0;
            cnt_set_d = cnt_set_q + IDX_W'(1);
          end else begin
            cnt_way_d = cnt_way_q + WAY_W'(1);
          end
        end
      end
      F_DONE: begin
        flush_done_d = 1'b1;
        state_d      = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= F_IDLE;
      cnt_set_q       <= '0;
      cnt_way_q       <= '0;
      wb_tag_q        <= '0;
      flush_done_q    <= 1'b0;
      valid_q         <= '0;
      dirty_q         <= '0;
      plru_q          <= '0;
      s1_vld_q        <= 1'b0;
      s1_idx_q        <= '0;
      s1_tag_q        <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_way_q       <= '0;
      rsp_vic_valid_q <= 1'b0;
      rsp_vic_dirty_q <= 1'b0;
      rsp_vic_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_set_q    <= cnt_set_d;
      cnt_way_q    <= cnt_way_d;
      wb_tag_q     <= wb_tag_d;
      flush_done_q <= flush_done_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      plru_q       <= plru_d;
      s1_vld_q     <= lk_acc;
      if (lk_acc) begin
        s1_idx_q <= lk_index;
        s1_tag_q <= lk_tag;
      end
      rsp_valid_q <= s1_vld_q;
      if (s1_vld_q) begin
        rsp_hit_q       <= hit;
        rsp_way_q       <= hit ? hit_way : vic_way;
        rsp_vic_valid_q <= !hit && vic_line.valid;
        rsp_vic_dirty_q <= !hit && vic_line.dirty;
        rsp_vic_tag_q   <= vic_line.tag[TAG_W-1:0];
      end
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_hit       = rsp_hit_q;
  assign rsp_way       = rsp_way_q;
  assign rsp_vic_valid = rsp_vic_valid_q;
  assign rsp_vic_dirty = rsp_vic_dirty_q;
  assign rsp_vic_tag   = rsp_vic_tag_q;
  assign flush_done    = flush_done_q;
  assign wb_valid      = (state_q == F_WB);
  assign wb_index      = cnt_set_q;
  assign wb_way        = cnt_way_q;
  assign wb_tag        = wb_tag_q;

  // Writes are dropped while the sweep owns the array.
  a_no_wr_in_flush: assert property (@(posedge clk) disable iff (!rst) !(wr_en && flush_busy));

endmodule
